core_ram_port_arbiter: RTL and testbench

CORE_RAM_PORT_ARBITER -- requirements
Module: core_ram_port_arbiter

---
 rtl/core_ram_port_arbiter_if.sv | 69 ++++++
 rtl/core_ram_port_arbiter.sv | 140 ++++++++++++++
 tb/tb_core_ram_port_arbiter.sv | 324 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/core_ram_port_arbiter_if.sv
// Bundle for the three requester ports (fetch, lsu, dbg), the shared RAM port and the stall flag.
// The arbiter uses the slave modport; the requester/RAM side uses master.
interface core_ram_port_arbiter_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    logic          i_fetch_req;
    logic          i_fetch_we;
    logic [AW-1:0] i_fetch_addr;
    logic [3:0]    i_fetch_byte_en;
    logic [DW-1:0] i_fetch_wdata;
    logic          o_fetch_gnt;
    logic          o_fetch_rvalid;
    logic [DW-1:0] o_fetch_rdata;
    logic          o_fetch_err;

    logic          i_lsu_req;
    logic          i_lsu_we;
    logic [AW-1:0] i_lsu_addr;
    logic [3:0]    i_lsu_byte_en;
    logic [DW-1:0] i_lsu_wdata;
    logic          o_lsu_gnt;
    logic          o_lsu_rvalid;
    logic [DW-1:0] o_lsu_rdata;
    logic          o_lsu_err;

    logic          i_dbg_req;
    logic          i_dbg_we;
    logic [AW-1:0] i_dbg_addr;
    logic [3:0]    i_dbg_byte_en;
    logic [DW-1:0] i_dbg_wdata;
    logic          o_dbg_gnt;
    logic          o_dbg_rvalid;
    logic [DW-1:0] o_dbg_rdata;
    logic          o_dbg_err;

    logic          o_ram_en;
    logic          o_ram_we;
    logic [AW-1:0] o_ram_addr;
    logic [3:0]    o_ram_byte_en;
    logic [DW-1:0] o_ram_wdata;
    logic [DW-1:0] i_ram_rdata;

    logic          o_stall;

    modport slave (
        input  i_fetch_req, i_fetch_we, i_fetch_addr, i_fetch_byte_en, i_fetch_wdata,
        output o_fetch_gnt, o_fetch_rvalid, o_fetch_rdata, o_fetch_err,
        input  i_lsu_req, i_lsu_we, i_lsu_addr, i_lsu_byte_en, i_lsu_wdata,
        output o_lsu_gnt, o_lsu_rvalid, o_lsu_rdata, o_lsu_err,
        input  i_dbg_req, i_dbg_we, i_dbg_addr, i_dbg_byte_en, i_dbg_wdata,
        output o_dbg_gnt, o_dbg_rvalid, o_dbg_rdata, o_dbg_err,
        output o_ram_en, o_ram_we, o_ram_addr, o_ram_byte_en, o_ram_wdata,
        input  i_ram_rdata,
        output o_stall
    );

    modport master (
        output i_fetch_req, i_fetch_we, i_fetch_addr, i_fetch_byte_en, i_fetch_wdata,
        input  o_fetch_gnt, o_fetch_rvalid, o_fetch_rdata, o_fetch_err,
        output i_lsu_req, i_lsu_we, i_lsu_addr, i_lsu_byte_en, i_lsu_wdata,
        input  o_lsu_gnt, o_lsu_rvalid, o_lsu_rdata, o_lsu_err,
        output i_dbg_req, i_dbg_we, i_dbg_addr, i_dbg_byte_en, i_dbg_wdata,
        input  o_dbg_gnt, o_dbg_rvalid, o_dbg_rdata, o_dbg_err,
        input  o_ram_en, o_ram_we, o_ram_addr, o_ram_byte_en, o_ram_wdata,
        output i_ram_rdata,
        input  o_stall
    );
endinterface

// File: rtl/core_ram_port_arbiter.sv
// Three-way single-port RAM arbiter (lsu > fetch > dbg) with 1-cycle read response routing.
// Define CORE_ARB_STARVE_GUARD_EN to add the dbg starvation guard; undefined gives pure fixed priority.
// Handshake: a requester holds req and its fields stable until gnt; gnt is the single accept cycle.
module core_ram_port_arbiter #(
    parameter int AW           = 32,
    parameter int DW           = 32,
    parameter int RAM_WORDS    = 4096,
    parameter int STARVE_LIMIT = 8
) (
    input logic                   i_clk,
    input logic                   i_rst,
    input logic                   i_clk_en,
    core_ram_port_arbiter_if.slave bus
);
    // Port index order everywhere: bit 0 fetch, bit 1 lsu, bit 2 dbg.
    logic [2:0]    req;
    logic [2:0]    we_v;
    logic [2:0]    oor;
    logic [2:0]    gnt;
    logic [2:0]    rvalid;
    logic          win;
    logic          w_we;
    logic          w_oor;
    logic          starve;
    logic          rsp_valid_q, rsp_valid_d;
    logic [2:0]    rsp_owner_q, rsp_owner_d;
    logic          rsp_err_q, rsp_err_d;

    assign req  = {bus.i_dbg_req, bus.i_lsu_req, bus.i_fetch_req};
    assign we_v = {bus.i_dbg_we, bus.i_lsu_we, bus.i_fetch_we};

    assign oor[0] = (bus.i_fetch_addr >> 2) >= AW'(RAM_WORDS);
    assign oor[1] = (bus.i_lsu_addr >> 2) >= AW'(RAM_WORDS);
    assign oor[2] = (bus.i_dbg_addr >> 2) >= AW'(RAM_WORDS);

`ifdef CORE_ARB_STARVE_GUARD_EN
    localparam int CW = $clog2(STARVE_LIMIT + 1);
    logic [CW-1:0] starve_cnt_q, starve_cnt_d;

    assign starve = req[2] && (starve_cnt_q == CW'(STARVE_LIMIT));

    always_comb begin
        starve_cnt_d = starve_cnt_q;
        if (i_clk_en) begin
            if (gnt[2] || !req[2]) begin
                starve_cnt_d = '0;
            end else if (starve_cnt_q != CW'(STARVE_LIMIT)) begin
                starve_cnt_d = starve_cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            starve_cnt_q <= '0;
        end else begin
            starve_cnt_q <= starve_cnt_d;
        end
    end
`else
    assign starve = 1'b0;
`endif

    always_comb begin
        gnt = 3'b000;
        if (!i_rst && i_clk_en) begin
            if (starve)      gnt = 3'b100;
            else if (req[1]) gnt = 3'b010;
            else if (req[0]) gnt = 3'b001;
            else if (req[2]) gnt = 3'b100;
        end
    end

    assign win   = |gnt;
    assign w_we  = |(gnt & we_v);
    assign w_oor = |(gnt & oor);

    // One-hot gnt makes the AND-OR mux a clean select of the winner's fields.
    always_comb begin
        bus.o_ram_en      = 1'b0;
        bus.o_ram_we      = 1'b0;
        bus.o_ram_addr    = '0;
        bus.o_ram_byte_en = '0;
        bus.o_ram_wdata   = '0;
        if (win && !w_oor) begin
            bus.o_ram_en      = 1'b1;
            bus.o_ram_we      = w_we;
            bus.o_ram_addr    = (({AW{gnt[0]}} & bus.i_fetch_addr) |
                                 ({AW{gnt[1]}} & bus.i_lsu_addr) |
                                 ({AW{gnt[2]}} & bus.i_dbg_addr)) >> 2;
            bus.o_ram_byte_en = ({4{gnt[0]}} & bus.i_fetch_byte_en) |
                                ({4{gnt[1]}} & bus.i_lsu_byte_en) |
                                ({4{gnt[2]}} & bus.i_dbg_byte_en);
            bus.o_ram_wdata   = ({DW{gnt[0]}} & bus.i_fetch_wdata) |
                                ({DW{gnt[1]}} & bus.i_lsu_wdata) |
                                ({DW{gnt[2]}} & bus.i_dbg_wdata);
        end
    end

    always_comb begin
        rsp_valid_d = rsp_valid_q;
        rsp_owner_d = rsp_owner_q;
        rsp_err_d   = rsp_err_q;
        if (i_clk_en) begin
            rsp_valid_d = win && !w_we;
            rsp_owner_d = gnt;
            rsp_err_d   = w_oor;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            rsp_valid_q <= 1'b0;
            rsp_owner_q <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            rsp_valid_q <= rsp_valid_d;
            rsp_owner_q <= rsp_owner_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    // Out-of-range reads complete with zero data and err instead of RAM data.
    assign rvalid = {3{rsp_valid_q && !i_rst}} & rsp_owner_q;

    assign bus.o_fetch_gnt    = gnt[0];
    assign bus.o_lsu_gnt      = gnt[1];
    assign bus.o_dbg_gnt      = gnt[2];
    assign bus.o_fetch_rvalid = rvalid[0];
    assign bus.o_lsu_rvalid   = rvalid[1];
    assign bus.o_dbg_rvalid   = rvalid[2];
    assign bus.o_fetch_rdata  = (rvalid[0] && !rsp_err_q) ? bus.i_ram_rdata : '0;
    assign bus.o_lsu_rdata    = (rvalid[1] && !rsp_err_q) ? bus.i_ram_rdata : '0;
    assign bus.o_dbg_rdata    = (rvalid[2] && !rsp_err_q) ? bus.i_ram_rdata : '0;
    assign bus.o_fetch_err    = (rvalid[0] && rsp_err_q) || (gnt[0] && we_v[0] && oor[0]);
    assign bus.o_lsu_err      = (rvalid[1] && rsp_err_q) || (gnt[1] && we_v[1] && oor[1]);
    assign bus.o_dbg_err      = (rvalid[2] && rsp_err_q) || (gnt[2] && we_v[2] && oor[2]);

    assign bus.o_stall = !i_rst && ((req[0] && !gnt[0]) || (req[1] && !gnt[1]));
endmodule

// File: tb/tb_core_ram_port_arbiter.sv
// Bench for core_ram_port_arbiter: directed scenarios then randomized traffic against a
// transaction-level reference model (priority rules, reference memory, expected read queue).
module tb_core_ram_port_arbiter;
  localparam int AW           = 32;
  localparam int DW           = 32;
  localparam int RAM_WORDS    = 4096;
  localparam int STARVE_LIMIT = 8;
`ifdef CORE_ARB_STARVE_GUARD_EN
  localparam bit GUARD = 1'b1;
`else
  localparam bit GUARD = 1'b0;
`endif

  logic clk, rst, clk_en, ram_init;
  logic          t_req [3];
  logic          t_we  [3];
  logic [AW-1:0] t_addr[3];
  logic [3:0]    t_be  [3];
  logic [DW-1:0] t_wd  [3];

  logic [DW-1:0] ram_mem [RAM_WORDS];
  logic [DW-1:0] ram_rdata;
  logic [DW-1:0] ref_mem [RAM_WORDS];

  int n_checks, n_pass;

  // reference model state
  bit            m_pv;
  int            m_po;
  bit            m_perr;
  int            m_cnt;
  logic [DW-1:0] exp_q[$];
  int            e_win;
  bit            e_oor;

  core_ram_port_arbiter_if #(.AW(AW), .DW(DW)) bus ();

  assign bus.i_fetch_req     = t_req[0];
  assign bus.i_fetch_we      = t_we[0];
  assign bus.i_fetch_addr    = t_addr[0];
  assign bus.i_fetch_byte_en = t_be[0];
  assign bus.i_fetch_wdata   = t_wd[0];
  assign bus.i_lsu_req       = t_req[1];
  assign bus.i_lsu_we        = t_we[1];
  assign bus.i_lsu_addr      = t_addr[1];
  assign bus.i_lsu_byte_en   = t_be[1];
  assign bus.i_lsu_wdata     = t_wd[1];
  assign bus.i_dbg_req       = t_req[2];
  assign bus.i_dbg_we        = t_we[2];
  assign bus.i_dbg_addr      = t_addr[2];
  assign bus.i_dbg_byte_en   = t_be[2];
  assign bus.i_dbg_wdata     = t_wd[2];
  assign bus.i_ram_rdata     = ram_rdata;

  core_ram_port_arbiter #(
    .AW(AW), .DW(DW), .RAM_WORDS(RAM_WORDS), .STARVE_LIMIT(STARVE_LIMIT)
  ) dut (
    .i_clk   (clk),
    .i_rst   (rst),
    .i_clk_en(clk_en),
    .bus     (bus)
  );

  // clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] init_val(input int i);
    return (i == 4) ? 32'hDEAD_BEEF : (32'(i) * 32'h9E37_79B9);
  endfunction

  // behavioural single-port RAM, 1-cycle read latency
  always @(posedge clk) begin
    if (ram_init) begin
      for (int i = 0; i < RAM_WORDS; i++) ram_mem[i] <= init_val(i);
      ram_rdata <= '0;
    end else if (bus.o_ram_en) begin
      if (bus.o_ram_we) begin
        for (int b = 0; b < 4; b++)
          if (bus.o_ram_byte_en[b])
            ram_mem[bus.o_ram_addr[11:0]][8*b +: 8] <= bus.o_ram_wdata[8*b +: 8];
      end else begin
        ram_rdata <= ram_mem[bus.o_ram_addr[11:0]];
      end
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  function automatic bit is_oor(input logic [AW-1:0] a);
    return int'(a >> 2) >= RAM_WORDS;
  endfunction

  task automatic set_req(input int p, input bit we, input logic [AW-1:0] a,
                         input logic [3:0] be, input logic [DW-1:0] wd);
    t_req[p] = 1'b1; t_we[p] = we; t_addr[p] = a; t_be[p] = be; t_wd[p] = wd;
  endtask

  // Called just after the falling edge: predict this cycle's outputs and compare.
  task automatic eval_cycle();
    logic [2:0]    e_gnt, e_rv, e_err, got;
    logic          e_en, e_we, e_stall;
    logic [DW-1:0] e_rd;
    #1;
    e_win = -1;
    if (!rst && clk_en) begin
      if (GUARD && t_req[2] && m_cnt >= STARVE_LIMIT) e_win = 2;
      else if (t_req[1]) e_win = 1;
      else if (t_req[0]) e_win = 0;
      else if (t_req[2]) e_win = 2;
    end
    e_oor = (e_win >= 0) && is_oor(t_addr[e_win]);
    e_gnt = (e_win >= 0) ? 3'(1 << e_win) : 3'b000;
    e_en  = (e_win >= 0) && !e_oor;
    e_we  = e_en && t_we[e_win];
    e_rv  = (!rst && m_pv) ? 3'(1 << m_po) : 3'b000;
    e_err = (m_perr ? e_rv : 3'b000) |
            (((e_win >= 0) && t_we[e_win] && e_oor) ? e_gnt : 3'b000);
    e_stall = !rst && ((t_req[0] && e_win != 0) || (t_req[1] && e_win != 1));
    e_rd  = (exp_q.size() > 0) ? exp_q[0] : '0;

    got = {bus.o_dbg_gnt, bus.o_lsu_gnt, bus.o_fetch_gnt};
    check("gnt", got, e_gnt);
    check("ram_en", bus.o_ram_en, e_en);
    check("ram_we", bus.o_ram_we, e_we);
    if (e_en) begin
      check("ram_addr", bus.o_ram_addr, t_addr[e_win] >> 2);
      check("ram_byte_en", bus.o_ram_byte_en, t_be[e_win]);
      if (e_we) check("ram_wdata", bus.o_ram_wdata, t_wd[e_win]);
    end
    check("stall", bus.o_stall, e_stall);
    got = {bus.o_dbg_rvalid, bus.o_lsu_rvalid, bus.o_fetch_rvalid};
    check("rvalid", got, e_rv);
    got = {bus.o_dbg_err, bus.o_lsu_err, bus.o_fetch_err};
    check("err", got, e_err);
    check("fetch_rdata", bus.o_fetch_rdata, e_rv[0] ? e_rd : '0);
    check("lsu_rdata", bus.o_lsu_rdata, e_rv[1] ? e_rd : '0);
    check("dbg_rdata", bus.o_dbg_rdata, e_rv[2] ? e_rd : '0);
  endtask

  // Advance the reference model across the rising edge, then wait for the next falling edge.
  task automatic tick();
    int w;
    logic [AW-1:0] word;
    w = e_win;
    if (rst) begin
      m_pv = 0; m_cnt = 0; exp_q.delete();
    end else if (clk_en) begin
      if (m_pv) void'(exp_q.pop_front());
      m_pv = 0;
      if (w >= 0) begin
        word = t_addr[w] >> 2;
        if (!t_we[w]) begin
          m_pv = 1; m_po = w; m_perr = e_oor;
          exp_q.push_back(e_oor ? '0 : ref_mem[word[11:0]]);
        end else if (!e_oor) begin
          for (int b = 0; b < 4; b++)
            if (t_be[w][b]) ref_mem[word[11:0]][8*b +: 8] = t_wd[w][8*b +: 8];
        end
      end
      if (w == 2 || !t_req[2]) m_cnt = 0;
      else if (m_cnt < STARVE_LIMIT) m_cnt++;
    end
    @(negedge clk);
  endtask

  initial begin
    logic [31:0] lv;
    int word;
    n_checks = 0; n_pass = 0;
    m_pv = 0; m_po = 0; m_perr = 0; m_cnt = 0;
    for (int p = 0; p < 3; p++) begin
      t_req[p] = 0; t_we[p] = 0; t_addr[p] = '0; t_be[p] = '0; t_wd[p] = '0;
    end
    for (int i = 0; i < RAM_WORDS; i++) ref_mem[i] = init_val(i);
    rst = 1; clk_en = 1; ram_init = 1;
    @(negedge clk);

    // reset state, with a request present to show stall/gnt are forced low
    set_req(1, 0, 32'h40, 4'hF, '0);
    eval_cycle();
    check("rst_stall", bus.o_stall, 1'b0);
    check("rst_lsu_gnt", bus.o_lsu_gnt, 1'b0);
    tick();
    ram_init = 0; t_req[1] = 0;
    eval_cycle(); tick();
    rst = 0;

    // fetch read of 0x10 returns RAM word 4
    set_req(0, 0, 32'h10, 4'hF, '0);
    eval_cycle();
    check("t1_fetch_gnt", bus.o_fetch_gnt, 1'b1);
    check("t1_ram_addr", bus.o_ram_addr, 32'h4);
    check("t1_stall", bus.o_stall, 1'b0);
    tick();
    t_req[0] = 0;
    eval_cycle();
    check("t1_rvalid", bus.o_fetch_rvalid, 1'b1);
    check("t1_rdata", bus.o_fetch_rdata, 32'hDEAD_BEEF);
    tick();

    // lsu write beats a simultaneous fetch read
    set_req(1, 1, 32'h100, 4'b0011, 32'h1234_5678);
    set_req(0, 0, 32'h20, 4'hF, '0);
    eval_cycle();
    check("t2_lsu_gnt", bus.o_lsu_gnt, 1'b1);
    check("t2_fetch_gnt0", bus.o_fetch_gnt, 1'b0);
    check("t2_ram_we", bus.o_ram_we, 1'b1);
    check("t2_byte_en", bus.o_ram_byte_en, 4'b0011);
    check("t2_stall", bus.o_stall, 1'b1);
    tick();
    t_req[1] = 0;
    eval_cycle();
    check("t2_fetch_gnt1", bus.o_fetch_gnt, 1'b1);
    tick();
    t_req[0] = 0;
    set_req(1, 0, 32'h100, 4'hF, '0);
    eval_cycle(); tick();
    t_req[1] = 0;
    eval_cycle();
    lv = init_val(64);
    check("t2_readback", bus.o_lsu_rdata, {lv[31:16], 16'h5678});
    tick();

    // lsu busy for 20 cycles while dbg waits
    set_req(1, 0, 32'h40, 4'hF, '0);
    set_req(2, 0, 32'h80, 4'hF, '0);
    for (int i = 0; i < 20; i++) begin
      eval_cycle();
      check("t3_dbg_gnt", bus.o_dbg_gnt, GUARD && (i == STARVE_LIMIT));
      check("t3_lsu_gnt", bus.o_lsu_gnt, !(GUARD && (i == STARVE_LIMIT)));
      tick();
      if (e_win == 2) t_req[2] = 0;
    end
    t_req[1] = 0;
    eval_cycle(); tick();
    t_req[2] = 0;
    eval_cycle(); tick();

    // out-of-range dbg read and write
    set_req(2, 0, 32'h4000, 4'hF, '0);
    eval_cycle();
    check("t4_dbg_gnt", bus.o_dbg_gnt, 1'b1);
    check("t4_ram_en", bus.o_ram_en, 1'b0);
    tick();
    set_req(2, 1, 32'h4004, 4'hF, 32'hCAFE_F00D);
    eval_cycle();
    check("t4_rvalid", bus.o_dbg_rvalid, 1'b1);
    check("t4_rdata", bus.o_dbg_rdata, 32'h0);
    check("t4_err", bus.o_dbg_err, 1'b1);
    tick();
    t_req[2] = 0;
    eval_cycle();
    check("t4_wr_no_rvalid", bus.o_dbg_rvalid, 1'b0);
    tick();

    // read granted right before reset must not respond
    set_req(0, 0, 32'h10, 4'hF, '0);
    eval_cycle(); tick();
    t_req[0] = 0; rst = 1;
    set_req(1, 0, 32'h44, 4'hF, '0);
    eval_cycle();
    check("t5_rst_rvalid", bus.o_fetch_rvalid, 1'b0);
    check("t5_rst_stall", bus.o_stall, 1'b0);
    tick();
    rst = 0; t_req[1] = 0;
    eval_cycle();
    check("t5_post_rvalid", bus.o_fetch_rvalid, 1'b0);
    tick();

    // clock enable low freezes grants and the starvation count
    set_req(1, 0, 32'h44, 4'hF, '0);
    set_req(2, 0, 32'h48, 4'hF, '0);
    for (int i = 0; i < 5; i++) begin eval_cycle(); tick(); end
    clk_en = 0;
    for (int i = 0; i < 3; i++) begin
      eval_cycle();
      check("t6_no_gnt", {bus.o_dbg_gnt, bus.o_lsu_gnt, bus.o_fetch_gnt}, 3'b000);
      check("t6_stall", bus.o_stall, 1'b1);
      tick();
    end
    clk_en = 1;
    eval_cycle();
    check("t6_lsu_resume", bus.o_lsu_gnt, 1'b1);
    tick();
    for (int k = 0; k < 5; k++) begin
      eval_cycle();
      check("t6_dbg_gnt", bus.o_dbg_gnt, GUARD && (k == 2));
      tick();
      if (e_win == 2) t_req[2] = 0;
    end
    for (int p = 0; p < 3; p++) t_req[p] = 0;
    eval_cycle(); tick();

    // randomized traffic
    for (int cyc = 0; cyc < 800; cyc++) begin
      rst    = ($urandom_range(0, 199) == 0);
      clk_en = ($urandom_range(0, 9) != 0);
      for (int p = 0; p < 3; p++) begin
        if (!t_req[p] || e_win == p) begin
          t_req[p] = ($urandom_range(0, 99) < ((p == 1) ? 55 : (p == 0) ? 45 : 35));
          word = ($urandom_range(0, 9) < 8) ? $urandom_range(0, 31)
                                            : $urandom_range(RAM_WORDS - 4, RAM_WORDS + 4);
          t_addr[p] = (AW'(word) << 2) | AW'($urandom_range(0, 3));
          t_we[p]   = (p == 0) ? 1'b0 : 1'($urandom_range(0, 1));
          t_be[p]   = 4'($urandom_range(0, 15));
          t_wd[p]   = $urandom;
        end
      end
      eval_cycle(); tick();
    end
    rst = 0; clk_en = 1;
    for (int p = 0; p < 3; p++) t_req[p] = 0;
    eval_cycle(); tick();
    eval_cycle(); tick();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
